// File: rtl/multi_beep_timer.sv
// multi_beep_timer: CHANNELS independent square-wave tone generators, each
// continuous or single-shot, plus a programmable frame tick (TICKn) with a
// maskable, write-1-to-clear frame interrupt (IRQn).
// Everything advances on the CE tick enable.
// Optional feature: define BEEP_LEN_PROG_EN to get a per-channel programmable
// single-shot length register (reg 3).
// Without it, reg 3 reads 0 and single-shot length is fixed at SINGLE_LEN frames.
module multi_beep_timer #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 12,
  parameter int TICK_PERIOD = 6000,
  parameter int SINGLE_LEN  = 20
) (
  input  logic                CLKSYS,
  input  logic                RESETBn,
  input  logic                CE,
  input  logic [3:0]          ADDR,
  input  logic                WR,
  input  logic                RD,
  input  logic [7:0]          DIN,
  output logic [7:0]          DOUT,
  output logic [CHANNELS-1:0] SOUND,
  output logic                SOUND_MIX,
  output logic                TICKn,
  output logic                IRQn
);

  // Register map: ADDR = {bank[1:0], reg[1:0]}; bank 3 is the global bank.
  localparam logic [1:0] BANK_GLOBAL = 2'd3;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DIVLO   = 2'd1;
  localparam logic [1:0] REG_DIVHI   = 2'd2;
  localparam logic [1:0] REG_LEN     = 2'd3;
  localparam logic [1:0] REG_TPLO    = 2'd0;
  localparam logic [1:0] REG_TPHI    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQCTL  = 2'd3;

  logic [1:0] w_bank;
  logic [1:0] w_reg;
  logic       w_glob_wr;
  assign w_bank    = ADDR[3:2];
  assign w_reg     = ADDR[1:0];
  assign w_glob_wr = WR & (w_bank == BANK_GLOBAL);

  // Frame tick state. r_tp is the programmed period; r_tp_act is the period
  // in force, reloaded from r_tp only at a wrap so a reprogram never cuts a
  // frame short.
  logic [15:0] r_tp;
  logic [15:0] r_tp_act;
  logic [15:0] r_frame_cnt;
  logic [15:0] w_tp_m1;
  logic        w_frame_pulse;
  logic        r_tickn;
  logic        r_pending;
  logic        r_irq_en;

  // Per-channel state.
  logic [CHANNELS-1:0] r_cont;
  logic [CHANNELS-1:0] r_single;
  logic [CHANNELS-1:0] r_active;
  logic [CHANNELS-1:0] r_phase;
  logic [DIV_W-1:0]    r_div   [CHANNELS];
  logic [DIV_W-1:0]    r_cnt   [CHANNELS];
  logic [7:0]          r_fcnt  [CHANNELS];

  // Per-channel helpers.
  logic [CHANNELS-1:0] w_ch_sel;
  logic [15:0]         w_div_ext [CHANNELS];
  logic [DIV_W-1:0]    w_div_m1  [CHANNELS];
  logic [7:0]          w_len_raw [CHANNELS];
  logic [7:0]          w_len_eff [CHANNELS];

`ifdef BEEP_LEN_PROG_EN
  logic [7:0] r_len [CHANNELS];
`endif

  // Period-1 with a zero period behaving like a period of one.
  assign w_tp_m1       = (r_tp_act == 16'd0) ? 16'd0 : r_tp_act - 16'd1;
  assign w_frame_pulse = CE & (r_frame_cnt >= w_tp_m1);

  // Channel decode plus divider and length terms with zero treated as one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    w_ch_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_ch_sel[i]  = (w_bank == 2'(i));
      w_div_ext[i] = 16'(r_div[i]);
      w_div_m1[i]  = (r_div[i] == '0) ? '0 : r_div[i] - 1'b1;
`ifdef BEEP_LEN_PROG_EN
      w_len_raw[i] = r_len[i];
`else
      w_len_raw[i] = 8'(SINGLE_LEN);
`endif
      w_len_eff[i] = (w_len_raw[i] == 8'd0) ? 8'd1 : w_len_raw[i];
    end
  end

  // Frame counter, TICKn square wave, period registers and interrupt state.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      r_tp        <= 16'(TICK_PERIOD);
      r_tp_act    <= 16'(TICK_PERIOD);
      r_frame_cnt <= 16'd0;
      r_tickn     <= 1'b1;
      r_pending   <= 1'b0;
      r_irq_en    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (CE) begin
        if (w_frame_pulse) begin
          r_frame_cnt <= 16'd0;
          r_tp_act    <= r_tp;
          r_tickn     <= ~r_tickn;
        end else begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
      if (w_glob_wr && w_reg == REG_TPLO) r_tp[7:0]  <= DIN;
      if (w_glob_wr && w_reg == REG_TPHI) r_tp[15:8] <= DIN;
      if (w_glob_wr && w_reg == REG_IRQCTL) r_irq_en <= DIN[0];
      // A frame pulse in the same cycle as a clear leaves pending set.
      if (w_frame_pulse) begin
        r_pending <= 1'b1;
      end else if (w_glob_wr && w_reg == REG_STATUS && DIN[0]) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Channel mode, tone divider and single-shot frame counting.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      r_cont   <= '0;
      r_single <= '0;
      r_active <= '0;
      r_phase  <= '0;
      // NOTE: these arrays are a handful of control registers, not a RAM,
      // so they are reset element by element like any other flop.
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i]  <= '1;
        r_cnt[i]  <= '0;
        r_fcnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (WR && w_ch_sel[i] && w_reg == REG_CTRL) begin
          // A CTRL write restarts the channel and overrides a coincident expiry.
          r_cont[i]   <= DIN[7];
          r_single[i] <= DIN[6];
          r_active[i] <= DIN[0] & (DIN[7] | DIN[6]);
          r_cnt[i]    <= '0;
          r_phase[i]  <= 1'b0;
          r_fcnt[i]   <= 8'd0;
        end else if (r_active[i]) begin
          if (CE) begin
            // >= keeps the wrap bounded if DIV is lowered below the count.
            if (r_cnt[i] >= w_div_m1[i]) begin
              r_cnt[i]   <= '0;
              r_phase[i] <= ~r_phase[i];
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
          // Active without continuous means single-shot: count frames to LEN.
          if (w_frame_pulse && !r_cont[i]) begin
            r_fcnt[i] <= r_fcnt[i] + 8'd1;
            if (r_fcnt[i] + 8'd1 == w_len_eff[i]) r_active[i] <= 1'b0;
          end
        end
        if (WR && w_ch_sel[i] && w_reg == REG_DIVLO) begin
          r_div[i] <= DIV_W'({w_div_ext[i][15:8], DIN});
        end
        if (WR && w_ch_sel[i] && w_reg == REG_DIVHI) begin
          r_div[i] <= DIV_W'({DIN, w_div_ext[i][7:0]});
        end
      end
    end
  end

`ifdef BEEP_LEN_PROG_EN
  // Programmable single-shot length per channel.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      for (int i = 0; i < CHANNELS; i++) r_len[i] <= 8'(SINGLE_LEN);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (WR && w_ch_sel[i] && w_reg == REG_LEN) r_len[i] <= DIN;
      end
    end
  end
`endif

  // Combinational register readback; zero when not reading.
  always_comb begin
    DOUT = 8'h00;
    if (RD) begin
      if (w_bank == BANK_GLOBAL) begin
        case (w_reg)
          REG_TPLO:   DOUT = r_tp[7:0];
          REG_TPHI:   DOUT = r_tp[15:8];
          REG_STATUS: DOUT = {4'd0, 3'(r_active), r_pending};
          default:    DOUT = {7'd0, r_irq_en};
        endcase
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_ch_sel[i]) begin
            case (w_reg)
              REG_CTRL:  DOUT = {r_cont[i], r_single[i], 5'd0, r_active[i]};
              REG_DIVLO: DOUT = w_div_ext[i][7:0];
              REG_DIVHI: DOUT = w_div_ext[i][15:8];
`ifdef BEEP_LEN_PROG_EN
              default:   DOUT = w_len_raw[i];
`else
              default:   DOUT = 8'h00;
`endif
            endcase
          end
        end
      end
    end
  end

  assign SOUND     = r_active & r_phase;
  assign SOUND_MIX = |SOUND;
  assign TICKn     = r_tickn;
  assign IRQn      = ~(r_pending & r_irq_en);

endmodule

// File: tb/tb_multi_beep_timer.sv
// Directed self-checking bench for multi_beep_timer (default parameters).
// CE is pulsed every other CLKSYS cycle; outputs are sampled on the falling edge.
module tb_multi_beep_timer;

`ifdef BEEP_LEN_PROG_EN
  localparam int         EXP_LEN     = 3;
  localparam logic [7:0] EXP_LEN_RST = 8'h14;
  localparam logic [7:0] EXP_LEN_RD  = 8'h03;
`else
  localparam int         EXP_LEN     = 20;
  localparam logic [7:0] EXP_LEN_RST = 8'h00;
  localparam logic [7:0] EXP_LEN_RD  = 8'h00;
`endif

  logic       CLKSYS  = 1'b0;
  logic       RESETBn = 1'b0;
  logic       CE      = 1'b0;
  logic [3:0] ADDR    = 4'd0;
  logic       WR      = 1'b0;
  logic       RD      = 1'b0;
  logic [7:0] DIN     = 8'd0;
  wire  [7:0] DOUT;
  wire  [1:0] SOUND;
  wire        SOUND_MIX;
  wire        TICKn;
  wire        IRQn;

  int errors   = 0;
  int checks   = 0;
  int ce_total = 0;

  multi_beep_timer dut (
    .CLKSYS    (CLKSYS),
    .RESETBn   (RESETBn),
    .CE        (CE),
    .ADDR      (ADDR),
    .WR        (WR),
    .RD        (RD),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .SOUND     (SOUND),
    .SOUND_MIX (SOUND_MIX),
    .TICKn     (TICKn),
    .IRQn      (IRQn)
  );

  always #5 CLKSYS = ~CLKSYS;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // n CE pulses, each one cycle wide followed by an idle cycle.
  task automatic ce_n(input int n);
    for (int k = 0; k < n; k++) begin
      CE = 1'b1;
      @(negedge CLKSYS);
      CE = 1'b0;
      @(negedge CLKSYS);
      ce_total++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ADDR = a; DIN = d; WR = 1'b1;
    @(negedge CLKSYS);
    WR = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    ADDR = a; RD = 1'b1;
    #1;
    d = DOUT;
    RD = 1'b0;
  endtask

  // Pulse CE until TICKn changes or the budget runs out.
  task automatic wait_toggle(input int max_ce, output int n, output bit ok);
    logic t0;
    t0 = TICKn;
    n  = 0;
    while (TICKn === t0 && n < max_ce) begin
      ce_n(1);
      n++;
    end
    ok = (TICKn !== t0);
  endtask

  task automatic test_reset();
    logic [3:0] addrs [11] = '{4'd14, 4'd15, 4'd1, 4'd2, 4'd5, 4'd6,
                               4'd12, 4'd13, 4'd0, 4'd9, 4'd3};
    logic [7:0] exps  [11] = '{8'h00, 8'h00, 8'hFF, 8'h0F, 8'hFF, 8'h0F,
                               8'h70, 8'h17, 8'h00, 8'h00, EXP_LEN_RST};
    logic [7:0] d;
    RESETBn = 1'b0;
    repeat (3) @(negedge CLKSYS);
    RESETBn = 1'b1;
    @(negedge CLKSYS);
    for (int i = 0; i < 11; i++) begin
      rd(addrs[i], d);
      checks++;
      if (d !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", addrs[i], d, exps[i]);
      end
    end
    ADDR = 4'd1; RD = 1'b0; #1;
    checks++;
    if (DOUT !== 8'h00) begin errors++; $display("FAIL dout_idle: got %h expected 00", DOUT); end
    checks++;
    if ({SOUND, SOUND_MIX, TICKn, IRQn} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00011", {SOUND, SOUND_MIX, TICKn, IRQn});
    end
  endtask

  task automatic test_tone();
    logic [7:0] d;
    wr(4'd1, 8'd125);
    wr(4'd2, 8'd0);
    wr(4'd0, 8'h81);
    rd(4'd0, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL tone_ctrl_rd: got %h expected 81", d); end
    rd(4'd14, d);
    checks++;
    if ((d & 8'h0E) !== 8'h02) begin errors++; $display("FAIL tone_status: got %h expected 02", d & 8'h0E); end
    ce_n(124);
    checks++;
    if (SOUND[0] !== 1'b0) begin errors++; $display("FAIL tone_ce124: got %b expected 0", SOUND[0]); end
    ce_n(1);
    checks++;
    if ({SOUND[0], SOUND_MIX} !== 2'b11) begin errors++; $display("FAIL tone_ce125: got %b expected 11", {SOUND[0], SOUND_MIX}); end
    ce_n(124);
    checks++;
    if (SOUND[0] !== 1'b1) begin errors++; $display("FAIL tone_ce249: got %b expected 1", SOUND[0]); end
    ce_n(1);
    checks++;
    if (SOUND[0] !== 1'b0) begin errors++; $display("FAIL tone_ce250: got %b expected 0", SOUND[0]); end
    ce_n(125);
    checks++;
    if (SOUND[0] !== 1'b1) begin errors++; $display("FAIL tone_ce375: got %b expected 1", SOUND[0]); end
    wr(4'd0, 8'h00);
    checks++;
    if ({SOUND[0], SOUND_MIX} !== 2'b00) begin errors++; $display("FAIL tone_stop: got %b expected 00", {SOUND[0], SOUND_MIX}); end
  endtask

  task automatic test_frame_period();
    logic [7:0] d;
    int n;
    bit ok;
    wr(4'd12, 8'd100);
    wr(4'd13, 8'd0);
    wait_toggle(7000, n, ok);
    checks++;
    if (!ok || ce_total != 6000) begin
      errors++;
      $display("FAIL first_frame: toggled=%0d at CE %0d expected CE 6000", ok, ce_total);
    end
    wait_toggle(200, n, ok);
    checks++;
    if (!ok || n != 100) begin errors++; $display("FAIL frame_len: got %0d CE expected 100", n); end
    rd(4'd14, d);
    checks++;
    if (d[0] !== 1'b1 || IRQn !== 1'b1) begin
      errors++;
      $display("FAIL pending_masked: got pend=%b irqn=%b expected 1 1", d[0], IRQn);
    end
    wr(4'd14, 8'h01);
    rd(4'd14, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL pending_w1c: got %b expected 0", d[0]); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int n;
    bit ok;
    wr(4'd7, 8'd3);
    wr(4'd5, 8'd0);
    wr(4'd6, 8'd0);
    rd(4'd7, d);
    checks++;
    if (d !== EXP_LEN_RD) begin errors++; $display("FAIL len_rd: got %h expected %h", d, EXP_LEN_RD); end
    wr(4'd4, 8'h41);
    rd(4'd4, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL single_ctrl_rd: got %h expected 41", d); end
    rd(4'd14, d);
    checks++;
    if ((d & 8'h0E) !== 8'h04) begin errors++; $display("FAIL single_status: got %h expected 04", d & 8'h0E); end
    ce_n(1);
    checks++;
    if (SOUND[1] !== 1'b1) begin errors++; $display("FAIL div0_ce1: got %b expected 1", SOUND[1]); end
    ce_n(1);
    checks++;
    if (SOUND[1] !== 1'b0) begin errors++; $display("FAIL div0_ce2: got %b expected 0", SOUND[1]); end
    for (int f = 1; f <= EXP_LEN; f++) begin
      wait_toggle(200, n, ok);
      rd(4'd14, d);
      checks++;
      if (!ok || d[2] !== (f < EXP_LEN)) begin
        errors++;
        $display("FAIL single_frame%0d: toggled=%0d active=%b expected %b", f, ok, d[2], f < EXP_LEN);
      end
    end
    rd(4'd4, d);
    checks++;
    if (d !== 8'h40 || SOUND[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got ctrl=%h snd=%b expected 40 0", d, SOUND[1]);
    end
  endtask

  task automatic test_continuous_priority();
    logic [7:0] d;
    int n;
    bit ok;
    wr(4'd7, 8'd1);
    wr(4'd4, 8'hC1);
    for (int f = 1; f <= 11; f++) begin
      wait_toggle(200, n, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL cont_timeout: frame %0d got no toggle expected toggle", f);
      end
    end
    rd(4'd14, d);
    checks++;
    if (d[2] !== 1'b1) begin errors++; $display("FAIL cont_active: got %b expected 1", d[2]); end
    rd(4'd4, d);
    checks++;
    if (d !== 8'hC1) begin errors++; $display("FAIL cont_ctrl_rd: got %h expected C1", d); end
    wr(4'd4, 8'h00);
    rd(4'd14, d);
    checks++;
    if (d[2] !== 1'b0 || SOUND[1] !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: got act=%b snd=%b expected 0 0", d[2], SOUND[1]);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    logic t0;
    int n;
    bit ok;
    wr(4'd15, 8'h01);
    wr(4'd14, 8'h01);
    checks++;
    if (IRQn !== 1'b1) begin errors++; $display("FAIL irq_cleared: got %b expected 1", IRQn); end
    wr(4'd12, 8'd50);
    wait_toggle(200, n, ok);
    checks++;
    if (!ok || IRQn !== 1'b0) begin errors++; $display("FAIL irq_assert: toggled=%0d irqn=%b expected 0", ok, IRQn); end
    wr(4'd14, 8'h01);
    checks++;
    if (IRQn !== 1'b1) begin errors++; $display("FAIL irq_w1c: got %b expected 1", IRQn); end
    n = 0;
    while (IRQn === 1'b1 && n < 200) begin
      ce_n(1);
      n++;
    end
    checks++;
    if (n != 50) begin errors++; $display("FAIL irq_period: got %0d CE expected 50", n); end
    wr(4'd14, 8'h01);
    checks++;
    if (IRQn !== 1'b1) begin errors++; $display("FAIL irq_w1c2: got %b expected 1", IRQn); end
    ce_n(49);
    t0 = TICKn;
    ADDR = 4'd14; DIN = 8'h01; WR = 1'b1; CE = 1'b1;
    @(negedge CLKSYS);
    WR = 1'b0; CE = 1'b0;
    @(negedge CLKSYS);
    rd(4'd14, d);
    checks++;
    if (TICKn === t0 || IRQn !== 1'b0 || d[0] !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: got tick_changed=%b irqn=%b pend=%b expected 1 0 1",
               TICKn !== t0, IRQn, d[0]);
    end
  endtask

  task automatic test_reset_mid_tone();
    logic [7:0] d;
    wr(4'd1, 8'd3);
    wr(4'd2, 8'd0);
    wr(4'd0, 8'h81);
    wr(4'd5, 8'd3);
    wr(4'd6, 8'd0);
    wr(4'd4, 8'h81);
    ce_n(3);
    checks++;
    if ({SOUND, SOUND_MIX} !== 3'b111) begin errors++; $display("FAIL both_tones: got %b expected 111", {SOUND, SOUND_MIX}); end
    #2;
    RESETBn = 1'b0;
    #1;
    checks++;
    if ({SOUND, SOUND_MIX, TICKn, IRQn} !== 5'b00011) begin
      errors++;
      $display("FAIL async_reset_out: got %b expected 00011", {SOUND, SOUND_MIX, TICKn, IRQn});
    end
    rd(4'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL async_reset_ctrl: got %h expected 00", d); end
    rd(4'd1, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL async_reset_div: got %h expected FF", d); end
    rd(4'd12, d);
    checks++;
    if (d !== 8'h70) begin errors++; $display("FAIL async_reset_tp: got %h expected 70", d); end
    rd(4'd15, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL async_reset_irqctl: got %h expected 00", d); end
    rd(4'd14, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL async_reset_status: got %h expected 00", d); end
    @(negedge CLKSYS);
    RESETBn = 1'b1;
    @(negedge CLKSYS);
  endtask

  initial begin
    test_reset();
    test_tone();
    test_frame_period();
    test_single();
    test_continuous_priority();
    test_irq();
    test_reset_mid_tone();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_beep_timer.md
Name: multi_beep_timer

Overview:
- Parametrised successor of the single-buzzer timer: CHANNELS independent tone generators, each with programmable pitch, single-shot or continuous mode, plus a programmable periodic frame tick with a maskable interrupt.
- Sits on the main CPU I/O decode, clocked by CLKSYS and advanced by a 300 kHz tick enable.
- Channel outputs feed the sound mixer; TICKn/IRQn replace the fixed 20 ms NMI source.

Parameters:
- CHANNELS, 2, number of tone channels (1..3).
- DIV_W, 12, tone half-period counter width (1..16).
- TICK_PERIOD, 6000, reset value of frame period in CE ticks (20 ms at 300 kHz).
- SINGLE_LEN, 20, single-shot length in frames when programmable length is compiled out.

Ports:
- CLKSYS  in  1  system clock, all state on rising edge
- RESETBn  in  1  asynchronous active-low reset
- CE  in  1  300 kHz tick enable, one CLKSYS cycle wide
- ADDR  in  4  register address {ch[1:0], reg[1:0]}; ch=3 is the global bank
- WR  in  1  write strobe, sampled each CLKSYS edge
- RD  in  1  read select
- DIN  in  8  write data
- DOUT  out  8  read data, combinational; 8'h00 when RD=0
- SOUND  out  CHANNELS  per-channel square wave
- SOUND_MIX  out  1  OR of SOUND
- TICKn  out  1  frame square wave, toggles every frame
- IRQn  out  1  active-low frame interrupt

Behaviour:
- Reset: all channels idle, DIV=all-ones, LEN=SINGLE_LEN, TP=TICK_PERIOD, IRQ enable 0, pending 0, SOUND=0, SOUND_MIX=0, TICKn=1, IRQn=1, all counters 0.
- Channel regs: 0 CTRL {bit7 continuous, bit6 single, bit0 speaker}; 1 DIVLO; 2 DIVHI (upper bits beyond DIV_W ignored, read 0); 3 LEN (8-bit frames). Unimplemented channels read 0, writes ignored.
- Global regs: 12 TPLO; 13 TPHI; 14 STATUS {bit0 IRQ pending, bits[3:1] channel active}, write 1 to bit0 clears pending; 15 IRQCTL bit0 enable.
- CTRL write: mode decided from DIN.
  - speaker=1 & continuous=1: continuous; continuous has priority over single.
  - speaker=1 & single=1 & continuous=0: single-shot.
  - Any other value: idle next cycle.
  - Every CTRL write clears the tone counter, forces the channel phase low and clears the frame count. WR held N cycles = N writes.
- Tone: on CE while active, counter increments. At counter == DIV-1 it wraps to 0 and phase toggles. DIV=0 is treated as 1. SOUND[i] = active & phase. Readback of CTRL: {continuous, single, 5'b0, active}.
- Single-shot: counts frame pulses after activation. On the pulse making count == LEN (LEN=0 treated as 1) the channel goes idle. Duration is (LEN-1, LEN] frames.
- Frame: on CE, frame counter increments. At TP-1 it wraps (TP=0 treated as 1), emits a one-CLKSYS frame pulse, toggles TICKn, and sets pending.
  - Writing TPLO/TPHI takes effect at the next wrap.
  - IRQn = ~(pending & enable).
- Simultaneous events:
  - CTRL write vs single-shot expiry in the same cycle: write wins.
  - Frame pulse vs pending W1C in the same cycle: set wins.
- Reset mid-tone returns everything to reset values within the same cycle (asynchronous).

Optional Feature:
- Macro BEEP_LEN_PROG_EN.
- Defined: LEN register per channel as above.
- Undefined: no LEN storage; reg 3 reads 8'h00, writes ignored; single-shot length fixed at SINGLE_LEN.

Test Plan:
- Reset, then read all regs -> STATUS=8'h00, IRQCTL=8'h00, DIVLO=8'hFF, DIVHI=8'h0F, SOUND=0, TICKn=1, IRQn=1.
- ch0 DIV=125, CTRL=8'h81 -> SOUND[0] toggles every 125 CE, 1200 Hz; CTRL=8'h00 -> SOUND[0]=0 next cycle.
- ch1 LEN=3, TP=100, CTRL=8'h41 -> active bit set; idle on 3rd frame pulse; STATUS bit2 returns 0; CTRL readback 8'h40.
- CTRL=8'hC1 (single+continuous) with LEN=1 -> tone persists past 10 frames.
- IRQCTL=1, TP=50 -> IRQn low 50 CE after start; W1C STATUS=8'h01 -> IRQn high; W1C coincident with a frame pulse -> IRQn stays low.
- Both channels active, RESETBn pulsed low mid-tone -> SOUND=0, SOUND_MIX=0, all regs at reset values immediately.
